// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: N-master to 1-slave AXI read arbiter with round-robin AR, ID tagging and outstanding limit
module easyaxi_rd_arb #(
  parameter int MST_NUM = 2,
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTS = 4,
  localparam int MW = MST_NUM > 1 ? $clog2(MST_NUM) : 1,
  localparam int SID_W = ID_W + MW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MST_NUM-1:0]        mst_arvalid,
  output logic [MST_NUM-1:0]        mst_arready,
  input  logic [MST_NUM*ID_W-1:0]   mst_arid,
  input  logic [MST_NUM*ADDR_W-1:0] mst_araddr,
  input  logic [MST_NUM*8-1:0]      mst_arlen,
  input  logic [MST_NUM*3-1:0]      mst_arsize,
  input  logic [MST_NUM*2-1:0]      mst_arburst,
  output logic [MST_NUM-1:0]        mst_rvalid,
  input  logic [MST_NUM-1:0]        mst_rready,
  output logic [MST_NUM*ID_W-1:0]   mst_rid,
  output logic [MST_NUM*DATA_W-1:0] mst_rdata,
  output logic [MST_NUM*2-1:0]      mst_rresp,
  output logic [MST_NUM-1:0]        mst_rlast,
  output logic                      slv_arvalid,
  input  logic                      slv_arready,
  output logic [SID_W-1:0]          slv_arid,
  output logic [ADDR_W-1:0]         slv_araddr,
  output logic [7:0]                slv_arlen,
  output logic [2:0]                slv_arsize,
  output logic [1:0]                slv_arburst,
  input  logic                      slv_rvalid,
  output logic                      slv_rready,
  input  logic [SID_W-1:0]          slv_rid,
  input  logic [DATA_W-1:0]         slv_rdata,
  input  logic [1:0]                slv_rresp,
  input  logic                      slv_rlast,
  output logic                      route_err
);
  logic [MW-1:0] rr_ptr, g, idx;
  logic [3:0] outs_cnt;
  logic buf_full, any_v, accept, illegal, r_done;
  // scan downward so the first valid master at or after rr_ptr is the last to win
  always_comb begin
    g = '0;
    any_v = 1'b0;
    for (int k = MST_NUM - 1; k >= 0; k--) begin
      if (mst_arvalid[(int'(rr_ptr) + k) % MST_NUM]) begin
        g = MW'((int'(rr_ptr) + k) % MST_NUM);
        any_v = 1'b1;
      end
    end
  end
  assign accept = !rst && any_v && (!buf_full || slv_arready) && outs_cnt < 4'(MAX_OUTS);
  assign mst_arready = accept ? MST_NUM'(1) << g : '0;
  assign slv_arvalid = buf_full;
  assign idx = slv_rid[SID_W-1:ID_W];
  assign illegal = int'(idx) >= MST_NUM;
  // beats tagged with a non-existent master are sunk
  always_comb begin
    slv_rready = 1'b1;
    mst_rvalid = '0;
    for (int j = 0; j < MST_NUM; j++) begin
      if (idx == MW'(j)) begin
        mst_rvalid[j] = slv_rvalid;
        slv_rready = mst_rready[j];
      end
    end
  end
  assign r_done = slv_rvalid && slv_rready && slv_rlast;
  assign mst_rid = {MST_NUM{slv_rid[ID_W-1:0]}};
  assign mst_rdata = {MST_NUM{slv_rdata}};
  assign mst_rresp = {MST_NUM{slv_rresp}};
  assign mst_rlast = {MST_NUM{slv_rlast}};
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      slv_arid <= '0;
      slv_araddr <= '0;
      slv_arlen <= '0;
      slv_arsize <= '0;
      slv_arburst <= '0;
      rr_ptr <= '0;
      outs_cnt <= '0;
      route_err <= 1'b0;
    end else begin
      if (accept) begin
        buf_full <= 1'b1;
        slv_arid <= {g, mst_arid[g*ID_W +: ID_W]};
        slv_araddr <= mst_araddr[g*ADDR_W +: ADDR_W];
        slv_arlen <= mst_arlen[g*8 +: 8];
        slv_arsize <= mst_arsize[g*3 +: 3];
        slv_arburst <= mst_arburst[g*2 +: 2];
        rr_ptr <= int'(g) == MST_NUM - 1 ? '0 : g + MW'(1);
      end else if (slv_arready) buf_full <= 1'b0;
      if (accept && !r_done) outs_cnt <= outs_cnt + 4'd1;
      else if (r_done && !accept && outs_cnt != 4'd0) outs_cnt <= outs_cnt - 4'd1;
      if (slv_rvalid && illegal) route_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// tb_easyaxi_rd_arb: scoreboard bench for the read arbiter, 2-master and 3-master instances
module tb_easyaxi_rd_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic [1:0] a_mst_arvalid, a_mst_arready, a_mst_rvalid, a_mst_rready, a_mst_rlast;
  logic [7:0] a_mst_arid, a_mst_rid;
  logic [63:0] a_mst_araddr, a_mst_rdata;
  logic [15:0] a_mst_arlen;
  logic [5:0] a_mst_arsize;
  logic [3:0] a_mst_arburst, a_mst_rresp;
  logic a_slv_arvalid, a_slv_arready, a_slv_rvalid, a_slv_rready, a_slv_rlast, a_route_err;
  logic [4:0] a_slv_arid, a_slv_rid;
  logic [31:0] a_slv_araddr, a_slv_rdata;
  logic [7:0] a_slv_arlen;
  logic [2:0] a_slv_arsize;
  logic [1:0] a_slv_arburst, a_slv_rresp;

  logic [2:0] b_mst_arvalid, b_mst_arready, b_mst_rvalid, b_mst_rready, b_mst_rlast;
  logic [11:0] b_mst_arid, b_mst_rid;
  logic [95:0] b_mst_araddr, b_mst_rdata;
  logic [23:0] b_mst_arlen;
  logic [8:0] b_mst_arsize;
  logic [5:0] b_mst_arburst, b_mst_rresp;
  logic b_slv_arvalid, b_slv_arready, b_slv_rvalid, b_slv_rready, b_slv_rlast, b_route_err;
  logic [5:0] b_slv_arid, b_slv_rid;
  logic [31:0] b_slv_araddr, b_slv_rdata;
  logic [7:0] b_slv_arlen;
  logic [2:0] b_slv_arsize;
  logic [1:0] b_slv_arburst, b_slv_rresp;

  easyaxi_rd_arb #(.MST_NUM(2), .MAX_OUTS(4)) dut_a (
    .clk(clk), .rst(rst),
    .mst_arvalid(a_mst_arvalid), .mst_arready(a_mst_arready), .mst_arid(a_mst_arid),
    .mst_araddr(a_mst_araddr), .mst_arlen(a_mst_arlen), .mst_arsize(a_mst_arsize),
    .mst_arburst(a_mst_arburst), .mst_rvalid(a_mst_rvalid), .mst_rready(a_mst_rready),
    .mst_rid(a_mst_rid), .mst_rdata(a_mst_rdata), .mst_rresp(a_mst_rresp), .mst_rlast(a_mst_rlast),
    .slv_arvalid(a_slv_arvalid), .slv_arready(a_slv_arready), .slv_arid(a_slv_arid),
    .slv_araddr(a_slv_araddr), .slv_arlen(a_slv_arlen), .slv_arsize(a_slv_arsize),
    .slv_arburst(a_slv_arburst), .slv_rvalid(a_slv_rvalid), .slv_rready(a_slv_rready),
    .slv_rid(a_slv_rid), .slv_rdata(a_slv_rdata), .slv_rresp(a_slv_rresp), .slv_rlast(a_slv_rlast),
    .route_err(a_route_err)
  );

  easyaxi_rd_arb #(.MST_NUM(3), .MAX_OUTS(2)) dut_b (
    .clk(clk), .rst(rst),
    .mst_arvalid(b_mst_arvalid), .mst_arready(b_mst_arready), .mst_arid(b_mst_arid),
    .mst_araddr(b_mst_araddr), .mst_arlen(b_mst_arlen), .mst_arsize(b_mst_arsize),
    .mst_arburst(b_mst_arburst), .mst_rvalid(b_mst_rvalid), .mst_rready(b_mst_rready),
    .mst_rid(b_mst_rid), .mst_rdata(b_mst_rdata), .mst_rresp(b_mst_rresp), .mst_rlast(b_mst_rlast),
    .slv_arvalid(b_slv_arvalid), .slv_arready(b_slv_arready), .slv_arid(b_slv_arid),
    .slv_araddr(b_slv_araddr), .slv_arlen(b_slv_arlen), .slv_arsize(b_slv_arsize),
    .slv_arburst(b_slv_arburst), .slv_rvalid(b_slv_rvalid), .slv_rready(b_slv_rready),
    .slv_rid(b_slv_rid), .slv_rdata(b_slv_rdata), .slv_rresp(b_slv_rresp), .slv_rlast(b_slv_rlast),
    .route_err(b_route_err)
  );

  // AR entry: {id(8), addr(32), len(8), size(3), burst(2)}; R entry: {master(8), rid(4), data(32), resp(2), last}
  logic [52:0] a_q[$], b_q[$];
  logic [46:0] ra_q[$];
  logic [52:0] a_e, b_e;
  logic [46:0] r_e;

  always @(negedge clk) begin
    if (!rst && a_slv_arvalid && a_slv_arready) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_ar_unexpected got id=%h addr=%h expected no AR", a_slv_arid, a_slv_araddr);
      end else begin
        a_e = a_q.pop_front();
        if ({3'b0, a_slv_arid, a_slv_araddr, a_slv_arlen, a_slv_arsize, a_slv_arburst} !== a_e) begin
          errors++;
          $display("FAIL a_ar_fields got %h expected %h",
                   {3'b0, a_slv_arid, a_slv_araddr, a_slv_arlen, a_slv_arsize, a_slv_arburst}, a_e);
        end
      end
    end
    if (!rst && b_slv_arvalid && b_slv_arready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_ar_unexpected got id=%h addr=%h expected no AR", b_slv_arid, b_slv_araddr);
      end else begin
        b_e = b_q.pop_front();
        if ({2'b0, b_slv_arid, b_slv_araddr, b_slv_arlen, b_slv_arsize, b_slv_arburst} !== b_e) begin
          errors++;
          $display("FAIL b_ar_fields got %h expected %h",
                   {2'b0, b_slv_arid, b_slv_araddr, b_slv_arlen, b_slv_arsize, b_slv_arburst}, b_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        if (a_mst_rvalid[j] && a_mst_rready[j]) begin
          checks++;
          if (ra_q.size() == 0) begin
            errors++;
            $display("FAIL a_r_unexpected got beat on master %0d expected none", j);
          end else begin
            r_e = ra_q.pop_front();
            if ({8'(j), a_mst_rid[j*4 +: 4], a_mst_rdata[j*32 +: 32], a_mst_rresp[j*2 +: 2], a_mst_rlast[j]} !== r_e) begin
              errors++;
              $display("FAIL a_r_beat got %h expected %h",
                       {8'(j), a_mst_rid[j*4 +: 4], a_mst_rdata[j*32 +: 32], a_mst_rresp[j*2 +: 2], a_mst_rlast[j]}, r_e);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired, simulation expected to finish earlier");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_mst_arvalid = '0; a_mst_rready = '0; a_slv_arready = 1'b0; a_slv_rvalid = 1'b0;
    a_slv_rid = '0; a_slv_rdata = '0; a_slv_rresp = '0; a_slv_rlast = 1'b0;
    b_mst_arvalid = '0; b_mst_rready = '0; b_slv_arready = 1'b0; b_slv_rvalid = 1'b0;
    b_slv_rid = '0; b_slv_rdata = '0; b_slv_rresp = '0; b_slv_rlast = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_mst_arvalid = 2'b11;
    b_mst_arvalid = 3'b111;
    step;
    @(negedge clk);
    checks++;
    if (a_mst_arready !== 2'b00 || b_mst_arready !== 3'b000) begin
      errors++;
      $display("FAIL reset_arready got a=%b b=%b expected 0", a_mst_arready, b_mst_arready);
    end
    do_reset;
    @(negedge clk);
    checks++;
    if ({a_slv_arvalid, a_slv_arid, a_slv_araddr, a_slv_arlen, a_slv_arsize, a_slv_arburst, a_route_err} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs got arvalid=%b id=%h addr=%h err=%b expected 0",
               a_slv_arvalid, a_slv_arid, a_slv_araddr, a_route_err);
    end
    checks++;
    if ({b_slv_arvalid, b_slv_arid, b_slv_araddr, b_slv_arlen, b_slv_arsize, b_slv_arburst, b_route_err} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs got arvalid=%b id=%h addr=%h err=%b expected 0",
               b_slv_arvalid, b_slv_arid, b_slv_araddr, b_route_err);
    end
    step;
  endtask

  task automatic test_single_ar;
    a_mst_arid = 8'h30;
    a_mst_araddr = {32'h100, 32'h0};
    a_mst_arlen = {8'd3, 8'd0};
    a_slv_arready = 1'b1;
    a_mst_arvalid = 2'b10;
    a_q.push_back({8'h13, 32'h100, 8'd3, 3'd2, 2'd1});
    @(negedge clk);
    checks++;
    if (a_mst_arready !== 2'b10) begin
      errors++;
      $display("FAIL single_arready got %b expected 10", a_mst_arready);
    end
    step;
    a_mst_arvalid = 2'b00;
    @(negedge clk);
    checks++;
    if (a_slv_arvalid !== 1'b1 || a_slv_arid !== 5'h13 || a_slv_araddr !== 32'h100) begin
      errors++;
      $display("FAIL single_slv_ar got v=%b id=%h addr=%h expected 1/13/100", a_slv_arvalid, a_slv_arid, a_slv_araddr);
    end
    step;
    a_slv_rvalid = 1'b1;
    a_slv_rid = 5'h13;
    a_slv_rdata = 32'hD000;
    a_mst_rready = 2'b01;
    @(negedge clk);
    checks++;
    if (a_slv_rready !== 1'b0 || a_mst_rvalid !== 2'b10) begin
      errors++;
      $display("FAIL single_r_stall got rready=%b rvalid=%b expected 0/10", a_slv_rready, a_mst_rvalid);
    end
    step;
    a_mst_rready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      a_slv_rdata = 32'hD000 + 32'(i);
      a_slv_rresp = 2'(i);
      a_slv_rlast = (i == 3);
      ra_q.push_back({8'd1, 4'd3, 32'hD000 + 32'(i), 2'(i), i == 3});
      @(negedge clk);
      checks++;
      if (a_mst_rvalid !== 2'b10 || a_slv_rready !== 1'b1) begin
        errors++;
        $display("FAIL single_r_route beat %0d got rvalid=%b rready=%b expected 10/1", i, a_mst_rvalid, a_slv_rready);
      end
      step;
    end
    a_slv_rvalid = 1'b0;
    a_slv_rlast = 1'b0;
    step;
  endtask

  task automatic test_round_robin;
    logic [1:0] seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    do_reset;
    a_mst_arid = {4'd9, 4'd5};
    a_mst_araddr = {32'hB0, 32'hA0};
    a_mst_arlen = {8'd1, 8'd0};
    a_slv_arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_q.push_back({8'h05, 32'hA0, 8'd0, 3'd2, 2'd1});
      a_q.push_back({8'h19, 32'hB0, 8'd1, 3'd2, 2'd1});
    end
    a_mst_arvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (a_mst_arready !== seq[k]) begin
        errors++;
        $display("FAIL rr_grant cycle %0d got %b expected %b", k, a_mst_arready, seq[k]);
      end
      step;
    end
    a_mst_arvalid = 2'b00;
    a_mst_rready = 2'b11;
    a_slv_rvalid = 1'b1;
    a_slv_rid = 5'h05;
    a_slv_rlast = 1'b1;
    a_slv_rresp = 2'd0;
    for (int i = 0; i < 4; i++) begin
      a_slv_rdata = 32'hE000 + 32'(i);
      ra_q.push_back({8'd0, 4'd5, 32'hE000 + 32'(i), 2'd0, 1'b1});
      step;
    end
    a_slv_rvalid = 1'b0;
    a_slv_rlast = 1'b0;
    a_q.push_back({8'h05, 32'hA0, 8'd0, 3'd2, 2'd1});
    a_mst_arvalid = 2'b11;
    @(negedge clk);
    checks++;
    if (a_mst_arready !== 2'b01) begin
      errors++;
      $display("FAIL rr_ptr_wrap got %b expected 01", a_mst_arready);
    end
    step;
    a_mst_arvalid = 2'b00;
    step;
    step;
  endtask

  task automatic test_backpressure;
    do_reset;
    a_slv_arready = 1'b0;
    a_q.push_back({8'h05, 32'hA0, 8'd0, 3'd2, 2'd1});
    a_q.push_back({8'h19, 32'hB0, 8'd1, 3'd2, 2'd1});
    a_mst_arvalid = 2'b11;
    @(negedge clk);
    checks++;
    if (a_mst_arready !== 2'b01) begin
      errors++;
      $display("FAIL bp_first got %b expected 01", a_mst_arready);
    end
    step;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_mst_arready !== 2'b00 || a_slv_arvalid !== 1'b1 || a_slv_arid !== 5'h05 || a_slv_araddr !== 32'hA0) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got arready=%b v=%b id=%h addr=%h expected 00/1/05/a0",
                 k, a_mst_arready, a_slv_arvalid, a_slv_arid, a_slv_araddr);
      end
      step;
    end
    a_slv_arready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_mst_arready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got %b expected 10", a_mst_arready);
    end
    step;
    a_mst_arvalid = 2'b00;
    step;
    step;
  endtask

  task automatic test_outstanding;
    logic [2:0] seq [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
    do_reset;
    b_mst_arid = 12'h002;
    b_mst_araddr = {64'h0, 32'h40};
    b_mst_arlen = '0;
    b_slv_arready = 1'b1;
    b_q.push_back({8'h02, 32'h40, 8'd0, 3'd2, 2'd1});
    b_q.push_back({8'h02, 32'h40, 8'd0, 3'd2, 2'd1});
    b_mst_arvalid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (b_mst_arready !== seq[k]) begin
        errors++;
        $display("FAIL outs_limit cycle %0d got %b expected %b", k, b_mst_arready, seq[k]);
      end
      step;
    end
    b_slv_rvalid = 1'b1;
    b_slv_rid = 6'h02;
    b_slv_rdata = 32'hBEEF;
    b_slv_rresp = 2'd1;
    b_slv_rlast = 1'b1;
    b_mst_rready = 3'b001;
    @(negedge clk);
    checks++;
    if (b_mst_arready !== 3'b000 || b_mst_rvalid !== 3'b001) begin
      errors++;
      $display("FAIL outs_rlast_cycle got arready=%b rvalid=%b expected 000/001", b_mst_arready, b_mst_rvalid);
    end
    checks++;
    if ({b_mst_rid, b_mst_rdata, b_mst_rresp, b_mst_rlast} !== {{3{4'h2}}, {3{32'hBEEF}}, {3{2'd1}}, 3'b111}) begin
      errors++;
      $display("FAIL r_broadcast got rid=%h rresp=%h rlast=%b expected 222/15/111", b_mst_rid, b_mst_rresp, b_mst_rlast);
    end
    step;
    b_slv_rvalid = 1'b0;
    b_slv_rlast = 1'b0;
    b_q.push_back({8'h02, 32'h40, 8'd0, 3'd2, 2'd1});
    @(negedge clk);
    checks++;
    if (b_mst_arready !== 3'b001) begin
      errors++;
      $display("FAIL outs_after_rlast got %b expected 001", b_mst_arready);
    end
    step;
    b_mst_arvalid = 3'b000;
    step;
    step;
  endtask

  task automatic test_simultaneous;
    logic [2:0] seq [4] = '{3'b001, 3'b001, 3'b001, 3'b000};
    do_reset;
    b_slv_arready = 1'b1;
    for (int i = 0; i < 3; i++) b_q.push_back({8'h02, 32'h40, 8'd0, 3'd2, 2'd1});
    b_mst_arvalid = 3'b001;
    b_mst_rready = 3'b001;
    for (int k = 0; k < 4; k++) begin
      b_slv_rvalid = (k == 1);
      b_slv_rlast = (k == 1);
      b_slv_rid = 6'h02;
      @(negedge clk);
      checks++;
      if (b_mst_arready !== seq[k]) begin
        errors++;
        $display("FAIL simul_cnt cycle %0d got %b expected %b", k, b_mst_arready, seq[k]);
      end
      step;
    end
    b_slv_rvalid = 1'b0;
    b_slv_rlast = 1'b0;
    b_mst_arvalid = 3'b000;
    step;
  endtask

  task automatic test_illegal_id;
    b_mst_arvalid = 3'b001;
    b_mst_rready = 3'b000;
    b_slv_rvalid = 1'b1;
    b_slv_rid = 6'h37;
    b_slv_rlast = 1'b1;
    @(negedge clk);
    checks++;
    if (b_slv_rready !== 1'b1 || b_mst_rvalid !== 3'b000 || b_mst_arready !== 3'b000 || b_route_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sink got rready=%b rvalid=%b arready=%b err=%b expected 1/000/000/0",
               b_slv_rready, b_mst_rvalid, b_mst_arready, b_route_err);
    end
    step;
    b_slv_rvalid = 1'b0;
    b_slv_rlast = 1'b0;
    b_q.push_back({8'h02, 32'h40, 8'd0, 3'd2, 2'd1});
    @(negedge clk);
    checks++;
    if (b_route_err !== 1'b1 || b_mst_arready !== 3'b001) begin
      errors++;
      $display("FAIL illegal_flag got err=%b arready=%b expected 1/001", b_route_err, b_mst_arready);
    end
    step;
    b_mst_arvalid = 3'b000;
    b_slv_rvalid = 1'b1;
    b_slv_rid = 6'h15;
    b_mst_rready = 3'b010;
    @(negedge clk);
    checks++;
    if (b_mst_rvalid !== 3'b010 || b_slv_rready !== 1'b1) begin
      errors++;
      $display("FAIL route_m1 got rvalid=%b rready=%b expected 010/1", b_mst_rvalid, b_slv_rready);
    end
    step;
    b_slv_rvalid = 1'b0;
    step;
    @(negedge clk);
    checks++;
    if (b_route_err !== 1'b1) begin
      errors++;
      $display("FAIL route_err_sticky got %b expected 1", b_route_err);
    end
    step;
    do_reset;
    @(negedge clk);
    checks++;
    if (b_route_err !== 1'b0 || b_slv_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL route_err_reset got err=%b arvalid=%b expected 0/0", b_route_err, b_slv_arvalid);
    end
    step;
  endtask

  initial begin
    a_mst_arvalid = '0; a_mst_rready = '0; a_mst_arid = '0; a_mst_araddr = '0; a_mst_arlen = '0;
    a_mst_arsize = {2{3'd2}}; a_mst_arburst = {2{2'd1}};
    a_slv_arready = 1'b0; a_slv_rvalid = 1'b0; a_slv_rid = '0; a_slv_rdata = '0; a_slv_rresp = '0; a_slv_rlast = 1'b0;
    b_mst_arvalid = '0; b_mst_rready = '0; b_mst_arid = '0; b_mst_araddr = '0; b_mst_arlen = '0;
    b_mst_arsize = {3{3'd2}}; b_mst_arburst = {3{2'd1}};
    b_slv_arready = 1'b0; b_slv_rvalid = 1'b0; b_slv_rid = '0; b_slv_rdata = '0; b_slv_rresp = '0; b_slv_rlast = 1'b0;
    test_reset;
    test_single_ar;
    test_round_robin;
    test_backpressure;
    test_outstanding;
    test_simultaneous;
    test_illegal_id;
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0 || ra_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got a=%0d b=%0d r=%0d pending expected 0", a_q.size(), b_q.size(), ra_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/easyaxi_rd_arb.md
# easyaxi_rd_arb

Parametrised N-master to 1-slave AXI read-channel arbiter. It generalises the fixed point-to-point master/slave read link into a shared slave port. AR requests are arbitrated round-robin, registered into a one-entry output buffer, tagged with the master index in the upper ID bits, and throttled by an outstanding-burst limit. R beats are routed back to the owning master by decoding those ID bits. The block sits between the master read controllers and a single slave read controller.

## Interface

Parameters:
- MST_NUM, 2: number of master ports, at least 2.
- ID_W, 4: master-side ID width.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MAX_OUTS, 4: maximum accepted-but-incomplete bursts, 1..15.
- Derived: MW = max(1, clog2(MST_NUM)); slave ID width SID_W = ID_W+MW.

Ports. Per-master buses are packed, master i at slice [i*W +: W].
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- mst_arvalid / mst_arready, in / out, MST_NUM each: per-master AR handshake.
- mst_arid, in, MST_NUM*ID_W: per-master AR ID.
- mst_araddr, in, MST_NUM*ADDR_W: per-master AR address.
- mst_arlen, in, MST_NUM*8: per-master AR length.
- mst_arsize, in, MST_NUM*3: per-master AR size.
- mst_arburst, in, MST_NUM*2: per-master AR burst type.
- mst_rvalid / mst_rready, out / in, MST_NUM each: per-master R handshake.
- mst_rid, out, MST_NUM*ID_W: per-master R ID.
- mst_rdata, out, MST_NUM*DATA_W: per-master R data.
- mst_rresp, out, MST_NUM*2: per-master R response.
- mst_rlast, out, MST_NUM: per-master R last.
- slv_arvalid / slv_arready, out / in, 1 each: slave AR handshake.
- slv_arid, out, SID_W: slave AR ID.
- slv_araddr, out, ADDR_W: slave AR address.
- slv_arlen, out, 8: slave AR length.
- slv_arsize, out, 3: slave AR size.
- slv_arburst, out, 2: slave AR burst type.
- slv_rvalid / slv_rready, in / out, 1 each: slave R handshake.
- slv_rid, in, SID_W: slave R ID.
- slv_rdata, in, DATA_W: slave R data.
- slv_rresp, in, 2: slave R response.
- slv_rlast, in, 1: slave R last.
- route_err, out, 1: sticky flag, set by an R beat whose ID index is at least MST_NUM.

## Operation

- **Round-robin pointer:** rr_ptr holds MW bits. Combinational grant goes to the first valid master at or after rr_ptr, wrapping. On an AR handshake with master g, rr_ptr becomes (g+1) mod MST_NUM.
- **Output buffer:** one entry, with flag buf_full.
- **Accept condition:** accept = any valid & (!buf_full | slv_arready) & (outs_cnt < MAX_OUTS). mst_arready[g] = accept; all other arready bits are 0.
- **Buffer load:** on accept, load {g, arid} into slv_arid, load the other AR fields, and set buf_full. buf_full clears on a slave AR handshake with no simultaneous accept.
- **slv_arvalid:** equals buf_full. Buffer contents stay stable while slv_arvalid=1 and slv_arready=0.
- **outs_cnt:** 4 bits.
  - +1 on a master AR accept.
  - −1 on a slave R handshake with rlast=1.
  - Both in the same cycle: count unchanged.
  - The count never underflows; a decrement at 0 is ignored.
- **R routing (combinational):** idx = slv_rid[SID_W-1:ID_W].
  - mst_rvalid[j] = slv_rvalid & (idx==j).
  - Every master sees slv_rid[ID_W-1:0], rdata, rresp and rlast.
  - slv_rready = mst_rready[idx].
- **Illegal index:** if idx >= MST_NUM, the beat is sunk (slv_rready=1), route_err is set, and rlast still decrements outs_cnt.
- **Burst interleaving:** R bursts are not reordered. Interleaving of IDs by the slave passes through unchanged.

## Timing

- **Reset values:**
  - slv_arvalid=0 and buf_full=0.
  - slv_arid, addr, len, size and burst = 0.
  - rr_ptr=0, outs_cnt=0, route_err=0.
  - mst_arready is all 0 while rst=1.
- **AR latency:** a master handshake in cycle N gives slv_arvalid=1 in cycle N+1.
- **Back-to-back:** with slv_arready held at 1, one AR per cycle is sustained.
- **R latency:** zero cycles, purely combinational.
- **Limit reached:** at outs_cnt==MAX_OUTS, arready stays 0 until the cycle after the rlast handshake. The decrement is registered, so the limit is never exceeded.
- **Reset mid-burst:** everything clears in the next cycle; in-flight bursts are forgotten.

## Test plan

- **Single AR:** MST_NUM=2. Master1 sends arid=3, araddr=0x100, arlen=3 → slv_arid=0x13 one cycle later. Four R beats with rid=0x13 reach master1 only; master0 rvalid stays 0.
- **Round-robin:** both masters hold arvalid for 4 handshakes with slv_arready=1 → grant order 0,1,0,1. rr_ptr ends at 0.
- **Backpressure:** slv_arready=0 for 5 cycles → slv_arid and slv_araddr stay stable. Exactly one master is accepted, then all arready stay 0 until the slave takes the AR.
- **Outstanding limit:** MAX_OUTS=2, no R returned → exactly 2 ARs accepted. An rlast handshake in cycle N → the next accept no earlier than N+1.
- **Simultaneous events and illegal ID:** AR accept plus rlast in the same cycle → outs_cnt unchanged. MST_NUM=3 with rid index 3 → beat sunk, route_err=1 and held until rst.
